// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the data-memory path.
//   size_t          access size encoding (11 is illegal and has no member)
//   state_t         dmem_arbiter transaction FSM states
//   lastByteOffset  distance from the first to the last byte of an access
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Returns bytes-1 for a legal size. The illegal size returns 0, which is
  // harmless because that size is rejected on its own.
  function automatic logic [1:0] lastByteOffset(input logic [1:0] size);
    case (size)
      SZ_BYTE: lastByteOffset = 2'd0;
      SZ_HALF: lastByteOffset = 2'd1;
      SZ_WORD: lastByteOffset = 2'd3;
      default: lastByteOffset = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: picks the addressed byte or halfword out of a little-endian
// 32-bit RAM word and sign- or zero-extends it. Purely combinational. The CPU
// writeback stage uses the same block.
//   rd_i        word read from RAM (address aligned down to 4)
//   offset_i    byte address bits [1:0]
//   size_i      access size (size_t encoding)
//   unsigned_i  1 = zero-extend, 0 = sign-extend
//   result_o    extended 32-bit load value (0 for the illegal size)
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] rd_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    case (offset_i)
      2'd0:    byteSel = rd_i[7:0];
      2'd1:    byteSel = rd_i[15:8];
      2'd2:    byteSel = rd_i[23:16];
      default: byteSel = rd_i[31:24];
    endcase
    // Half accesses are 2-aligned, so only offset bit 1 selects the lane.
    halfSel = offset_i[1] ? rd_i[31:16] : rd_i[15:0];
    case (size_i)
      SZ_BYTE: result_o = {{24{byteSel[7] & ~unsigned_i}}, byteSel};
      SZ_HALF: result_o = {{16{halfSel[15] & ~unsigned_i}}, halfSel};
      SZ_WORD: result_o = rd_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port controller for the byte-addressed data
// RAM. Each granted request is checked for alignment and range, driven to
// the RAM for one cycle, and answered with a one-cycle response pulse.
//   clk, rst          clock, asynchronous active-high reset
//   pN_req/we/size/unsigned/addr/wdata   request from port N (0 = CPU, 1 = aux)
//   pN_gnt            combinational grant
//   pN_rvalid/err/rdata  registered response, only for the owning port
//   ram_a/ram_wd/ram_sb/ram_sh/ram_sw    RAM address, write data, strobes
//   ram_rd            combinational RAM read of the aligned word
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int                        ADDRESS_LENGTH = 32,
  parameter logic [ADDRESS_LENGTH-1:0] ADDR_LO        = 32'h0001_0000,
  parameter logic [ADDRESS_LENGTH-1:0] ADDR_HI        = 32'h0001_FFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      p0_req,
  input  logic                      p0_we,
  input  logic [1:0]                p0_size,
  input  logic                      p0_unsigned,
  input  logic [ADDRESS_LENGTH-1:0] p0_addr,
  input  logic [ADDRESS_LENGTH-1:0] p0_wdata,
  output logic                      p0_gnt,
  output logic                      p0_rvalid,
  output logic                      p0_err,
  output logic [ADDRESS_LENGTH-1:0] p0_rdata,
  input  logic                      p1_req,
  input  logic                      p1_we,
  input  logic [1:0]                p1_size,
  input  logic                      p1_unsigned,
  input  logic [ADDRESS_LENGTH-1:0] p1_addr,
  input  logic [ADDRESS_LENGTH-1:0] p1_wdata,
  output logic                      p1_gnt,
  output logic                      p1_rvalid,
  output logic                      p1_err,
  output logic [ADDRESS_LENGTH-1:0] p1_rdata,
  output logic [ADDRESS_LENGTH-1:0] ram_a,
  output logic [ADDRESS_LENGTH-1:0] ram_wd,
  output logic                      ram_sb,
  output logic                      ram_sh,
  output logic                      ram_sw,
  input  logic [ADDRESS_LENGTH-1:0] ram_rd
);

  state_t                    state_q;
  logic                      last_q;
  logic                      owner_q;
  logic                      reqWe_q;
  logic                      reqUns_q;
  logic                      reqErr_q;
  logic [1:0]                reqSize_q;
  logic [ADDRESS_LENGTH-1:0] ramA_q;
  logic [ADDRESS_LENGTH-1:0] ramWd_q;
  logic                      ramSb_q;
  logic                      ramSh_q;
  logic                      ramSw_q;
  logic                      p0Rvalid_q;
  logic                      p0Err_q;
  logic [ADDRESS_LENGTH-1:0] p0Rdata_q;
  logic                      p1Rvalid_q;
  logic                      p1Err_q;
  logic [ADDRESS_LENGTH-1:0] p1Rdata_q;

  logic                      canGrant;
  logic                      gnt0;
  logic                      gnt1;
  logic                      we_d;
  logic                      uns_d;
  logic                      err_d;
  logic                      misaligned_d;
  logic [1:0]                size_d;
  logic [ADDRESS_LENGTH-1:0] addr_d;
  logic [ADDRESS_LENGTH-1:0] wdata_d;
  logic [ADDRESS_LENGTH:0]   lastByte_d;
  logic [ADDRESS_LENGTH-1:0] loadResult;

  // Arbitration and request checking. last_q names the port served last, so
  // on a conflict the other port wins. The winner's fields are muxed here so
  // the error check sees exactly what gets latched. The last-byte sum carries
  // one extra bit so an address near the top of the space cannot wrap.
  always_comb begin
    canGrant     = (state_q == IDLE) || (state_q == RESP);
    gnt0         = canGrant && p0_req && (!p1_req || last_q);
    gnt1         = canGrant && p1_req && (!p0_req || !last_q);
    we_d         = gnt1 ? p1_we       : p0_we;
    uns_d        = gnt1 ? p1_unsigned : p0_unsigned;
    size_d       = gnt1 ? p1_size     : p0_size;
    addr_d       = gnt1 ? p1_addr     : p0_addr;
    wdata_d      = gnt1 ? p1_wdata    : p0_wdata;
    misaligned_d = ((size_d == SZ_HALF) && addr_d[0]) ||
                   ((size_d == SZ_WORD) && (addr_d[1:0] != 2'b00));
    lastByte_d   = {1'b0, addr_d} +
                   {{(ADDRESS_LENGTH - 1){1'b0}}, lastByteOffset(size_d)};
    err_d        = (size_d == 2'b11) || misaligned_d || (addr_d < ADDR_LO) ||
                   (lastByte_d > {1'b0, ADDR_HI});
  end

  // ram_a is only non-zero in ACCESS, so its low bits are the lane offset.
  load_extract u_load_extract (
    .rd_i       (ram_rd),
    .offset_i   (ramA_q[1:0]),
    .size_i     (reqSize_q),
    .unsigned_i (reqUns_q),
    .result_o   (loadResult)
  );

  // Transaction FSM. The RAM outputs are loaded on the granting edge so
  // they are valid for exactly the ACCESS cycle, and they default back to
  // zero on every other edge. The response registers are loaded on the
  // ACCESS edge and likewise default to zero. Async reset clears the strobes
  // at once, which aborts a store still in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      reqWe_q    <= 1'b0;
      reqUns_q   <= 1'b0;
      reqErr_q   <= 1'b0;
      reqSize_q  <= 2'b00;
      ramA_q     <= '0;
      ramWd_q    <= '0;
      ramSb_q    <= 1'b0;
      ramSh_q    <= 1'b0;
      ramSw_q    <= 1'b0;
      p0Rvalid_q <= 1'b0;
      p0Err_q    <= 1'b0;
      p0Rdata_q  <= '0;
      p1Rvalid_q <= 1'b0;
      p1Err_q    <= 1'b0;
      p1Rdata_q  <= '0;
    end else begin
      ramA_q     <= '0;
      ramWd_q    <= '0;
      ramSb_q    <= 1'b0;
      ramSh_q    <= 1'b0;
      ramSw_q    <= 1'b0;
      p0Rvalid_q <= 1'b0;
      p0Err_q    <= 1'b0;
      p0Rdata_q  <= '0;
      p1Rvalid_q <= 1'b0;
      p1Err_q    <= 1'b0;
      p1Rdata_q  <= '0;
      case (state_q)
        IDLE, RESP: begin
          if (gnt0 || gnt1) begin
            state_q   <= ACCESS;
            last_q    <= gnt1;
            owner_q   <= gnt1;
            reqWe_q   <= we_d;
            reqUns_q  <= uns_d;
            reqErr_q  <= err_d;
            reqSize_q <= size_d;
            ramA_q    <= addr_d;
            if (we_d && !err_d) begin
              ramWd_q <= wdata_d;
              ramSb_q <= (size_d == SZ_BYTE);
              ramSh_q <= (size_d == SZ_HALF);
              ramSw_q <= (size_d == SZ_WORD);
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          if (owner_q) begin
            p1Rvalid_q <= 1'b1;
            p1Err_q    <= reqErr_q;
            p1Rdata_q  <= (!reqWe_q && !reqErr_q) ? loadResult : '0;
          end else begin
            p0Rvalid_q <= 1'b1;
            p0Err_q    <= reqErr_q;
            p0Rdata_q  <= (!reqWe_q && !reqErr_q) ? loadResult : '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = p0Rvalid_q;
  assign p0_err    = p0Err_q;
  assign p0_rdata  = p0Rdata_q;
  assign p1_rvalid = p1Rvalid_q;
  assign p1_err    = p1Err_q;
  assign p1_rdata  = p1Rdata_q;
  assign ram_a     = ramA_q;
  assign ram_wd    = ramWd_q;
  assign ram_sb    = ramSb_q;
  assign ram_sh    = ramSh_q;
  assign ram_sw    = ramSw_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// byte RAM attached to the RAM port and a separate reference memory used to
// predict load results.
module tb_dmem_arbiter;

  localparam logic [31:0] LO = 32'h0001_0000;
  localparam logic [31:0] HI = 32'h0001_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0Req, p0We, p0Uns, p1Req, p1We, p1Uns;
  logic [1:0]  p0Size, p1Size;
  logic [31:0] p0Addr, p0Wdata, p1Addr, p1Wdata;
  logic        p0Gnt, p0Rvalid, p0Err, p1Gnt, p1Rvalid, p1Err;
  logic [31:0] p0Rdata, p1Rdata;
  logic [31:0] ramA, ramWd, ramRd;
  logic        ramSb, ramSh, ramSw;

  int checkCount = 0;
  int failCount  = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0Req), .p0_we(p0We), .p0_size(p0Size), .p0_unsigned(p0Uns),
    .p0_addr(p0Addr), .p0_wdata(p0Wdata), .p0_gnt(p0Gnt), .p0_rvalid(p0Rvalid),
    .p0_err(p0Err), .p0_rdata(p0Rdata),
    .p1_req(p1Req), .p1_we(p1We), .p1_size(p1Size), .p1_unsigned(p1Uns),
    .p1_addr(p1Addr), .p1_wdata(p1Wdata), .p1_gnt(p1Gnt), .p1_rvalid(p1Rvalid),
    .p1_err(p1Err), .p1_rdata(p1Rdata),
    .ram_a(ramA), .ram_wd(ramWd), .ram_sb(ramSb), .ram_sh(ramSh), .ram_sw(ramSw),
    .ram_rd(ramRd)
  );

  always #5 clk = ~clk;

  // Startup contents shared by the RAM model and the reference memory.
  function automatic logic [7:0] initByte(input int i);
    return 8'((i * 7) + (i >> 8) * 13 + 5);
  endfunction

  // Behavioural RAM: combinational aligned-word read, byte writes on edge.
  logic [7:0] ramMem [0:65535];
  bit         memReady;
  int         rdBase;

  always_comb begin
    rdBase = 0;
    ramRd  = '0;
    if (ramA >= LO && ramA <= HI) begin
      rdBase = int'(ramA[15:0]) & 32'hFFFC;
      ramRd  = {ramMem[rdBase + 3], ramMem[rdBase + 2], ramMem[rdBase + 1], ramMem[rdBase]};
    end
  end

  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 65536; i++) ramMem[i] <= initByte(i);
      memReady <= 1'b1;
    end else begin
      if (ramSb) ramMem[ramA[15:0]] <= ramWd[7:0];
      if (ramSh) begin
        ramMem[ramA[15:0]]         <= ramWd[7:0];
        ramMem[ramA[15:0] + 16'd1] <= ramWd[15:8];
      end
      if (ramSw) begin
        for (int i = 0; i < 4; i++) ramMem[ramA[15:0] + 16'(i)] <= ramWd[8*i +: 8];
      end
    end
  end

  // Reference model: memory as a flat byte array, rules as plain arithmetic.
  logic [7:0] refMem [0:65535];

  function automatic bit modelErr(input logic [1:0] size, input logic [31:0] addr);
    longint bytes, a;
    if (size == 2'd3) return 1'b1;
    bytes = longint'(1) << size;
    a = addr;
    if (a % bytes != 0) return 1'b1;
    if (a < LO) return 1'b1;
    if (a + bytes - 1 > HI) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] size, input bit uns,
                                            input logic [31:0] addr);
    longint bytes, v;
    bytes = longint'(1) << size;
    v = 0;
    for (int i = 0; i < int'(bytes); i++)
      v += longint'(refMem[16'(addr[15:0] + 16'(i))]) << (8 * i);
    if (!uns && v >= (longint'(1) << (8 * bytes - 1))) v -= longint'(1) << (8 * bytes);
    return v[31:0];
  endfunction

  task automatic modelStore(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
    for (int i = 0; i < (1 << size); i++)
      refMem[16'(addr[15:0] + 16'(i))] = wdata[8*i +: 8];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0Req = req; p0We = we; p0Size = size; p0Uns = uns; p0Addr = addr; p0Wdata = wdata;
    end else begin
      p1Req = req; p1We = we; p1Size = size; p1Uns = uns; p1Addr = addr; p1Wdata = wdata;
    end
  endtask

  function automatic logic gntOf(input int port);
    return (port == 0) ? p0Gnt : p1Gnt;
  endfunction
  function automatic logic rvalidOf(input int port);
    return (port == 0) ? p0Rvalid : p1Rvalid;
  endfunction
  function automatic logic errOf(input int port);
    return (port == 0) ? p0Err : p1Err;
  endfunction
  function automatic logic [31:0] rdataOf(input int port);
    return (port == 0) ? p0Rdata : p1Rdata;
  endfunction

  // One isolated transaction from a single port; entered and left at
  // posedge+1 with the FSM idle.
  task automatic runTxn(input int port, input bit we, input logic [1:0] size,
                        input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit expErr, input logic [31:0] expRdata, input string tag);
    logic [2:0] expStb;
    expStb = (we && !expErr) ? ((size == 2'd0) ? 3'b100 : (size == 2'd1) ? 3'b010 : 3'b001)
                             : 3'b000;
    applyStimulus(port, 1'b1, we, size, uns, addr, wdata);
    #1;
    checkOutput({tag, " gnt"}, 32'(gntOf(port)), 32'd1);
    checkOutput({tag, " other gnt"}, 32'(gntOf(1 - port)), 32'd0);
    @(posedge clk); #1;
    applyStimulus(port, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    checkOutput({tag, " strobes"}, 32'({ramSb, ramSh, ramSw}), 32'(expStb));
    if (!expErr) checkOutput({tag, " ram_a"}, ramA, addr);
    if (expStb != 3'b000) checkOutput({tag, " ram_wd"}, ramWd, wdata);
    @(posedge clk); #1;
    checkOutput({tag, " rvalid"}, 32'(rvalidOf(port)), 32'd1);
    checkOutput({tag, " err"}, 32'(errOf(port)), 32'(expErr));
    checkOutput({tag, " rdata"}, rdataOf(port), expRdata);
    checkOutput({tag, " other rvalid"}, 32'(rvalidOf(1 - port)), 32'd0);
    checkOutput({tag, " resp strobes"}, 32'({ramSb, ramSh, ramSw}), 32'd0);
    if (we && !expErr) modelStore(size, addr, wdata);
    @(posedge clk); #1;
    checkOutput({tag, " rvalid drop"}, 32'(rvalidOf(port)), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          expErr;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 65536; i++) refMem[i] = initByte(i);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset gnt", 32'({p0Gnt, p1Gnt}), 32'd0);
    checkOutput("reset rvalid/err", 32'({p0Rvalid, p1Rvalid, p0Err, p1Err}), 32'd0);
    checkOutput("reset rdata", p0Rdata | p1Rdata, 32'd0);
    checkOutput("reset ram", ramA | ramWd | 32'({ramSb, ramSh, ramSw}), 32'd0);
    rst = 1'b0;

    // port, we, size, uns, addr, wdata, expErr, expRdata
    vecs.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 2'd0, 1'b0, 32'h0001_0007, 32'h0, 1'b0, 32'hFFFF_FFDE});
    vecs.push_back('{0, 1'b0, 2'd1, 1'b1, 32'h0001_0004, 32'h0, 1'b0, 32'h0000_BEEF});
    vecs.push_back('{1, 1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0, 1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{1, 1'b0, 2'd1, 1'b0, 32'h0001_0006, 32'h0, 1'b0, 32'hFFFF_DEAD});
    vecs.push_back('{0, 1'b0, 2'd0, 1'b1, 32'h0001_0005, 32'h0, 1'b0, 32'h0000_00BE});
    vecs.push_back('{0, 1'b1, 2'd0, 1'b0, 32'h0001_0010, 32'h1234_565A, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 2'd0, 1'b1, 32'h0001_0010, 32'h0, 1'b0, 32'h0000_005A});
    vecs.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h0001_0002, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1, 1'b0, 2'd1, 1'b0, 32'h0001_FFFF, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1, 1'b0, 2'd3, 1'b0, 32'h0001_0000, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h0000_FFFC, 32'h1111_2222, 1'b1, 32'h0});
    vecs.push_back('{1, 1'b1, 2'd2, 1'b0, 32'h0001_FFFC, 32'hCAFE_F00D, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 2'd2, 1'b1, 32'h0001_FFFC, 32'h0, 1'b0, 32'hCAFE_F00D});
    vecs.push_back('{0, 1'b1, 2'd1, 1'b0, 32'h0001_0012, 32'hAAAA_8001, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 2'd1, 1'b0, 32'h0001_0012, 32'h0, 1'b0, 32'hFFFF_8001});
    vecs.push_back('{1, 1'b0, 2'd0, 1'b0, 32'h0001_0010, 32'h0, 1'b0, 32'h0000_005A});

    for (int i = 0; i < vecs.size(); i++)
      runTxn(vecs[i].port, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
             vecs[i].wdata, vecs[i].expErr, vecs[i].expRdata, $sformatf("vec%0d", i));

    // Both ports request continuously right after reset: p0 wins first.
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0001_0006, 32'h0);
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput($sformatf("rr%0d p0 gnt", k), 32'(p0Gnt), 32'(k % 4 == 0));
      checkOutput($sformatf("rr%0d p1 gnt", k), 32'(p1Gnt), 32'(k % 4 == 2));
      checkOutput($sformatf("rr%0d p0 rvalid", k), 32'(p0Rvalid), 32'(k >= 2 && k % 4 == 2));
      checkOutput($sformatf("rr%0d p1 rvalid", k), 32'(p1Rvalid), 32'(k >= 4 && k % 4 == 0));
      if (p0Rvalid) checkOutput($sformatf("rr%0d p0 rdata", k), p0Rdata, 32'hDEAD_BEEF);
      if (p1Rvalid) checkOutput($sformatf("rr%0d p1 rdata", k), p1Rdata, 32'h0000_DEAD);
      @(posedge clk); #1;
    end
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-ACCESS of a byte store aborts it without a response.
    applyStimulus(0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0001_0010, 32'h0000_00A5);
    #1;
    checkOutput("abort gnt", 32'(p0Gnt), 32'd1);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    checkOutput("abort sb before rst", 32'(ramSb), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort strobes", 32'({ramSb, ramSh, ramSw}), 32'd0);
    checkOutput("abort ram_a", ramA, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("abort rvalid%0d", k), 32'({p0Rvalid, p1Rvalid}), 32'd0);
      @(posedge clk); #1;
    end
    runTxn(0, 1'b0, 2'd0, 1'b1, 32'h0001_0010, 32'h0, 1'b0, 32'h0000_005A, "abort reload");

    // p1 raises and withdraws its request while p0 owns the RAM.
    applyStimulus(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0);
    #1;
    checkOutput("wd p0 gnt", 32'(p0Gnt), 32'd1);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0);
    #1;
    checkOutput("wd p1 gnt access", 32'(p1Gnt), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("wd p1 gnt resp", 32'(p1Gnt), 32'd0);
    checkOutput("wd p0 rvalid", 32'(p0Rvalid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("wd p1 rvalid%0d", k), 32'(p1Rvalid), 32'd0);
      checkOutput($sformatf("wd p1 gnt%0d", k), 32'(p1Gnt), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("wd idle strobes", 32'({ramSb, ramSh, ramSw}), 32'd0);

    // Randomized single-port traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      int          port, r;
      bit          we, uns, expErr;
      logic [1:0]  size;
      logic [31:0] addr, wdata, expRdata;
      port  = int'($urandom % 2);
      we    = 1'($urandom);
      uns   = 1'($urandom);
      size  = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      wdata = $urandom;
      r     = int'($urandom % 10);
      if (r < 6) begin
        addr = LO + ($urandom % 32'h1_0000);
        if ($urandom % 4 != 0 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
      end else if (r < 8) begin
        addr = 32'h0001_FFF8 + ($urandom % 8);
      end else begin
        addr = 32'h0000_FFFC + ($urandom % 8);
      end
      expErr   = modelErr(size, addr);
      expRdata = (expErr || we) ? 32'h0 : modelLoad(size, uns, addr);
      runTxn(port, we, size, uns, addr, wdata, expErr, expRdata, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
